// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the RV32M sequencer: funct3 codes, FSM states and
// two's-complement helpers used by the divide path.
package muldiv_seq_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MLOAD = 3'd1,
    ST_MWAIT = 3'd2,
    ST_DCHK  = 3'd3,
    ST_DIV   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Magnitude of v when treated as signed; passthrough for unsigned operands.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq_div_unit.sv
// Unsigned restoring divider, one quotient bit per step. quo/rem present the
// values after the step currently in progress, so the owner can capture the
// final result on the same edge as the last step.
module div_unit
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] sub;
  logic            fits;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while the new quotient bit enters at the LSB.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = shifted >= {1'b0, dvs_q};
    sub     = shifted[XLEN-1:0] - dvs_q;
    rem     = fits ? sub : shifted[XLEN-1:0];
    quo     = {quo_q[XLEN-2:0], fits};
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= rem;
      quo_q <= quo;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M sequencer: steers MUL* to the external shift-add multiplier and runs
// DIV*/REM* on the internal restoring divider, presenting busy/done/result.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit DIV_EARLY = 1'b1
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  output logic            mul_ua,
  output logic            mul_ub,
  output logic            mul_hm,
  output logic            mul_load,
  input  logic            mul_busy,
  input  logic [XLEN-1:0] mul_out,
  output logic [2:0]      fsm_state
);

  // Handshake: start is sampled only in IDLE or DONE (the accept edge); busy
  // rises combinationally in that same cycle and stays high until DONE; done
  // pulses for one cycle while result holds the new value.

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] result_q;
  logic [5:0]      count;

  logic            accept;
  logic            is_signed;
  logic            want_rem;
  logic            div_zero;
  logic            overflow;
  logic            early;
  logic            neg_q;
  logic            neg_r;
  logic            last_iter;
  logic [XLEN-1:0] dvd_mag;
  logic [XLEN-1:0] dvs_mag;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] div_res;

  assign accept = start && (state == ST_IDLE || state == ST_DONE);

  // Divide decode works on the latched operands, stable from DCHK onward.
  always_comb begin
    is_signed   = ~f3_q[0];
    want_rem    = f3_q[1];
    div_zero    = (rs2_q == '0);
    overflow    = is_signed && (rs1_q == 32'h8000_0000) && (rs2_q == 32'hFFFF_FFFF);
    early       = DIV_EARLY && (div_zero || overflow);
    neg_q       = is_signed && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]) && !div_zero;
    neg_r       = is_signed && rs1_q[XLEN-1];
    dvd_mag     = mag32(rs1_q, is_signed);
    dvs_mag     = mag32(rs2_q, is_signed);
    last_iter   = (count == 6'd31);
    special_res = want_rem ? (div_zero ? rs1_q : '0)
                           : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);
    div_res     = want_rem ? neg32(rem, neg_r) : neg32(quo, neg_q);
  end

  div_unit #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .resetb   (resetb),
    .load     (state == ST_DCHK),
    .step     (state == ST_DIV),
    .dividend (dvd_mag),
    .divisor  (dvs_mag),
    .quo      (quo),
    .rem      (rem)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = funct3[2] ? ST_DCHK : ST_MLOAD;
      ST_MLOAD: state_nxt = mul_busy ? ST_MWAIT : ST_DONE;
      ST_MWAIT: if (!mul_busy) state_nxt = ST_DONE;
      ST_DCHK:  state_nxt = early ? ST_DONE : ST_DIV;
      ST_DIV:   if (last_iter) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = accept ? (funct3[2] ? ST_DCHK : ST_MLOAD) : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = accept || (state != ST_IDLE && state != ST_DONE);
    done     = (state == ST_DONE);
    mul_load = (state == ST_MLOAD);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      f3_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (accept) begin
      f3_q  <= funct3;
      rs1_q <= rs1;
      rs2_q <= rs2;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      count <= '0;
    end else if (state == ST_DCHK) begin
      count <= '0;
    end else if (state == ST_DIV) begin
      count <= count + 6'd1;
    end
  end

  // result only moves on the edge that enters DONE.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      result_q <= '0;
    end else begin
      unique case (state)
        ST_MLOAD, ST_MWAIT: if (!mul_busy) result_q <= mul_out;
        ST_DCHK:            if (early) result_q <= special_res;
        ST_DIV:             if (last_iter) result_q <= div_res;
        default:            result_q <= result_q;
      endcase
    end
  end

  assign result    = result_q;
  assign mul_a     = rs2_q;
  assign mul_b     = rs1_q;
  assign mul_ua    = (f3_q == F3_MULHSU) || (f3_q == F3_MULHU);
  assign mul_ub    = (f3_q == F3_MULHU);
  assign mul_hm    = (f3_q == F3_MULH) || (f3_q == F3_MULHSU) || (f3_q == F3_MULHU);
  assign fsm_state = state;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq with a behavioural shift-add multiplier (operand cache,
// one iteration per bit of |a|) wired to the mul_* port group.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done, mul_ua, mul_ub, mul_hm, mul_load, mul_busy;
  logic [31:0] result, mul_a, mul_b, mul_out;
  logic [2:0]  fsm_state;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32), .DIV_EARLY(1'b1)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .start     (start),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_ua    (mul_ua),
    .mul_ub    (mul_ub),
    .mul_hm    (mul_hm),
    .mul_load  (mul_load),
    .mul_busy  (mul_busy),
    .mul_out   (mul_out),
    .fsm_state (fsm_state)
  );

  // ---------------- multiplier model ----------------
  logic        cache_v;
  logic [31:0] c_a, c_b;
  logic        c_ua, c_ub;
  logic [5:0]  iter_left;
  logic        hit;
  logic [5:0]  n_iter;
  logic [63:0] ext_a, ext_b, prod;

  function automatic logic [5:0] bit_len(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) if (v[i]) n = 6'(i + 1);
    return n;
  endfunction

  always_comb begin
    hit      = cache_v && (mul_a == c_a) && (mul_b == c_b) &&
               (((mul_ua == c_ua) && (mul_ub == c_ub)) || !mul_hm);
    n_iter   = bit_len((mul_ua || !mul_a[31]) ? mul_a : (~mul_a + 32'd1));
    mul_busy = (mul_load && !hit && (n_iter != 0)) || (iter_left != 0);
    ext_a    = mul_ua ? {32'b0, mul_a} : {{32{mul_a[31]}}, mul_a};
    ext_b    = mul_ub ? {32'b0, mul_b} : {{32{mul_b[31]}}, mul_b};
    prod     = ext_a * ext_b;
    mul_out  = mul_busy ? 32'hDEAD_BEEF : (mul_hm ? prod[63:32] : prod[31:0]);
  end

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cache_v   <= 1'b0;
      c_a       <= '0;
      c_b       <= '0;
      c_ua      <= 1'b0;
      c_ub      <= 1'b0;
      iter_left <= '0;
    end else begin
      if (iter_left != 0) iter_left <= iter_left - 6'd1;
      if (mul_load) begin
        cache_v <= 1'b1;
        c_a     <= mul_a;
        c_b     <= mul_b;
        c_ua    <= mul_ua;
        c_ub    <= mul_ub;
        if (!hit && n_iter != 0) iter_left <= n_iter - 6'd1;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] mul_flags(input logic [2:0] f3);
    case (f3)
      F3_MUL:    return 3'b000;
      F3_MULH:   return 3'b001;
      F3_MULHSU: return 3'b101;
      F3_MULHU:  return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns 1ns after the accept edge T.
  task automatic drive_start(input string name, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    #1;
    check({name, " busy in start cycle"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = 3'($urandom_range(0, 7));
    rs1    = $urandom;
    rs2    = $urandom;
  endtask

  // lat = edge index after T at which done is seen; returns at the DONE negedge.
  task automatic wait_done(input string name, output int lat, output int loads);
    lat   = -1;
    loads = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mul_load) loads++;
      if (done) begin
        lat = k + 1;
        break;
      end
    end
    if (lat < 0) begin
      tests++;
      fails++;
      $display("FAIL %s: done not seen within 100 cycles", name);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic set_vec(input int i, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    vecs[i].f3  = f3;
    vecs[i].a   = a;
    vecs[i].b   = b;
    vecs[i].exp = exp;
    vecs[i].lat = lat;
  endtask

  initial begin
    int lat, loads;
    logic [31:0] last_exp;

    // multiply latency = 2 + bit length of |rs2| unless the operand cache hits
    set_vec(0,  F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 4);
    set_vec(1,  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    set_vec(2,  F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2);
    set_vec(3,  F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 4);
    set_vec(4,  F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    set_vec(5,  F3_DIV,    32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 34);
    set_vec(6,  F3_REM,    32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 34);
    set_vec(7,  F3_DIVU,   32'd64,        32'd7,         32'd9,         34);
    set_vec(8,  F3_REMU,   32'd64,        32'd7,         32'd1,         34);
    set_vec(9,  F3_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    set_vec(10, F3_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34);
    set_vec(11, F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 2);
    set_vec(12, F3_REM,    32'd5,         32'd0,         32'd5,         2);
    set_vec(13, F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    set_vec(14, F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);
    set_vec(15, F3_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 2);
    set_vec(16, F3_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 2);

    // reset state
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset mul_load", 32'(mul_load), 32'd0);
    check("reset result", result, 32'd0);
    check("reset mul_a", mul_a, 32'd0);
    check("reset mul_b", mul_b, 32'd0);
    check("reset mul flags", 32'({mul_ua, mul_ub, mul_hm}), 32'd0);
    check("reset state", 32'(fsm_state), 32'(ST_IDLE));
    resetb = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      drive_start($sformatf("v%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b);
      if (!vecs[i].f3[2])
        check($sformatf("v%0d mul flags", i), 32'({mul_ua, mul_ub, mul_hm}),
              32'(mul_flags(vecs[i].f3)));
      wait_done($sformatf("v%0d", i), lat, loads);
      check($sformatf("v%0d result", i), result, vecs[i].exp);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d mul_load pulses", i), 32'(loads), vecs[i].f3[2] ? 32'd0 : 32'd1);
      @(negedge clk);
      check($sformatf("v%0d done width", i), 32'(done), 32'd0);
      check($sformatf("v%0d result held", i), result, vecs[i].exp);
    end
    last_exp = vecs[NV-1].exp;

    // start while dividing is ignored; the old result stays visible
    drive_start("ign", F3_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    check("ign state", 32'(fsm_state), 32'(ST_DIV));
    start  = 1'b1;
    funct3 = F3_MUL;
    rs1    = 32'd3;
    rs2    = 32'd3;
    #1;
    check("ign busy", 32'(busy), 32'd1);
    check("ign old result", result, last_exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign", lat, loads);
    check("ign result", result, 32'd14);
    check("ign latency", 32'(lat + 5), 32'd34);
    check("ign mul_load pulses", 32'(loads), 32'd0);

    // back-to-back: accepted in the DONE cycle of the previous op
    drive_start("b2b", F3_MUL, 32'd5, 32'd6);
    wait_done("b2b", lat, loads);
    check("b2b result", result, 32'd30);
    check("b2b latency", 32'(lat), 32'd5);
    check("b2b mul_load pulses", 32'(loads), 32'd1);

    // asynchronous reset mid-divide
    @(negedge clk);
    drive_start("rst", F3_DIV, 32'hFFFF_FFEC, 32'd3);
    repeat (10) @(negedge clk);
    resetb = 1'b0;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", result, 32'd0);
    check("rst state", 32'(fsm_state), 32'(ST_IDLE));
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    drive_start("post", F3_MUL, 32'd7, 32'hFFFF_FFFD);
    wait_done("post", lat, loads);
    check("post result", result, 32'hFFFF_FFEB);
    check("post latency", 32'(lat), 32'd4);
    check("post mul_load pulses", 32'(loads), 32'd1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
